// File: rtl/bus_dec_pkg.sv
// rtl/bus_dec_pkg.sv - shared types and default sizes for the bus window decoder
package bus_dec_pkg;

  localparam int DEF_AW     = 16;
  localparam int DEF_NREG   = 8;
  localparam int DEF_WS_W   = 3;
  localparam int DEF_BANK_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Descriptor fields are sized by the package defaults; overriding AW/WS_W
  // on the decoder requires these constants to follow.
  typedef struct packed {
    logic                  valid;
    logic [DEF_AW-1:0]     base;
    logic [DEF_AW-1:0]     mask;
    logic [DEF_WS_W-1:0]   ws;
    logic                  bank;
  } win_desc_t;

endpackage

// File: rtl/bus_window_decoder_if.sv
// rtl/bus_window_decoder_if.sv - CPU bus, config and bank signals of one decoder instance
interface bus_window_decoder_if #(
  parameter int AW     = bus_dec_pkg::DEF_AW,
  parameter int NREG   = bus_dec_pkg::DEF_NREG,
  parameter int WS_W   = bus_dec_pkg::DEF_WS_W,
  parameter int BANK_W = bus_dec_pkg::DEF_BANK_W
);

  logic                    cfg_we;
  logic [$clog2(NREG)-1:0] cfg_idx;
  logic [AW-1:0]           cfg_base;
  logic [AW-1:0]           cfg_mask;
  logic [WS_W-1:0]         cfg_ws;
  logic                    cfg_bank;
  logic [AW-1:0]           cpu_ab;
  logic                    cpu_mreq;
  logic                    bank_we;
  logic [BANK_W-1:0]       bank_din;
  logic [NREG-1:0]         sel;
  logic                    miss;
  logic                    wait_n;
  logic [BANK_W-1:0]       bank_ab;

  modport master (
    output cfg_we, cfg_idx, cfg_base, cfg_mask, cfg_ws, cfg_bank,
    output cpu_ab, cpu_mreq, bank_we, bank_din,
    input  sel, miss, wait_n, bank_ab
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_base, cfg_mask, cfg_ws, cfg_bank,
    input  cpu_ab, cpu_mreq, bank_we, bank_din,
    output sel, miss, wait_n, bank_ab
  );

endinterface

// File: rtl/bus_window_match.sv
// rtl/bus_window_match.sv - combinational NREG-way window compare with lowest-index priority
module bus_window_match #(
  parameter int AW    = 16,
  parameter int NREG  = 8,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic [NREG-1:0]  i_valid,
  input  logic [AW-1:0]    i_base [NREG],
  input  logic [AW-1:0]    i_mask [NREG],
  input  logic [AW-1:0]    i_addr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top so the last (lowest) matching index is the one kept.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_valid[i] && ((i_addr & i_mask[i]) == (i_base[i] & i_mask[i]))) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_window_decoder.sv
// rtl/bus_window_decoder.sv - registered NREG-window CPU decoder with wait-state FSM
// Banked-ROM address extension is compiled in when BUS_WINDOW_BANK_EN is defined.
module bus_window_decoder
  import bus_dec_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int NREG   = DEF_NREG,
  parameter int WS_W   = DEF_WS_W,
  parameter int BANK_W = DEF_BANK_W
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  bus_window_decoder_if.slave  vif
);

  localparam int IDX_W = $clog2(NREG);

  win_desc_t       r_desc [NREG];
  state_t          r_state, w_state_nxt;
  logic [WS_W-1:0] r_cnt, w_cnt_nxt;
  logic [NREG-1:0] r_sel, w_sel_nxt;
  logic            r_miss, w_miss_nxt;
  logic            r_bank_sel, w_bank_sel_nxt;
  logic            r_mreq_q;

  logic [NREG-1:0]  w_valid;
  logic [AW-1:0]    w_base [NREG];
  logic [AW-1:0]    w_mask [NREG];
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  win_desc_t        w_win;
  logic             w_start;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_valid[i] = r_desc[i].valid;
      w_base[i]  = r_desc[i].base;
      w_mask[i]  = r_desc[i].mask;
    end
  end

  bus_window_match #(
    .AW   (AW),
    .NREG (NREG),
    .IDX_W(IDX_W)
  ) u_match (
    .i_valid(w_valid),
    .i_base (w_base),
    .i_mask (w_mask),
    .i_addr (vif.cpu_ab),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_win   = r_desc[w_idx];
  assign w_start = vif.cpu_mreq && !r_mreq_q;

  // Descriptor writes land at the clock edge, so a same-cycle decode sees the old entry.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_desc[i] <= '0;
    end else if (vif.cfg_we) begin
      r_desc[vif.cfg_idx] <= '{
        valid: 1'b1,
        base:  vif.cfg_base,
        mask:  vif.cfg_mask,
        ws:    vif.cfg_ws,
`ifdef BUS_WINDOW_BANK_EN
        bank:  vif.cfg_bank
`else
        bank:  1'b0
`endif
      };
    end
  end

  // r_mreq_q resets high so a strobe already asserted across reset is not decoded.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_miss     <= 1'b0;
      r_bank_sel <= 1'b0;
      r_mreq_q   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_miss     <= w_miss_nxt;
      r_bank_sel <= w_bank_sel_nxt;
      r_mreq_q   <= vif.cpu_mreq;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sel_nxt      = r_sel;
    w_miss_nxt     = r_miss;
    w_bank_sel_nxt = r_bank_sel;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_hit) begin
            w_sel_nxt      = NREG'(1) << w_idx;
            w_miss_nxt     = 1'b0;
            w_cnt_nxt      = w_win.ws;
            w_bank_sel_nxt = w_win.bank;
          end else begin
            w_sel_nxt      = '0;
            w_miss_nxt     = 1'b1;
            w_cnt_nxt      = '0;
            w_bank_sel_nxt = 1'b0;
          end
          w_state_nxt = (w_cnt_nxt == '0) ? HOLD : WAIT;
        end
      end
      WAIT: begin
        if (!vif.cpu_mreq) begin
          w_state_nxt    = IDLE;
          w_sel_nxt      = '0;
          w_miss_nxt     = 1'b0;
          w_cnt_nxt      = '0;
          w_bank_sel_nxt = 1'b0;
        end else if (r_cnt == WS_W'(1)) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - WS_W'(1);
        end
      end
      HOLD: begin
        if (!vif.cpu_mreq) begin
          w_state_nxt    = IDLE;
          w_sel_nxt      = '0;
          w_miss_nxt     = 1'b0;
          w_bank_sel_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_sel_nxt      = '0;
        w_miss_nxt     = 1'b0;
        w_cnt_nxt      = '0;
        w_bank_sel_nxt = 1'b0;
      end
    endcase
  end

  assign vif.sel    = r_sel;
  assign vif.miss   = r_miss;
  assign vif.wait_n = (r_state != WAIT);

`ifdef BUS_WINDOW_BANK_EN
  logic [BANK_W-1:0] r_bank;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_bank <= '0;
    else if (vif.bank_we) r_bank <= vif.bank_din;
  end

  // Follows the bank register live, so a mid-access bank write shows immediately.
  assign vif.bank_ab = r_bank_sel ? r_bank : '0;
`else
  logic w_unused_bank;
  assign w_unused_bank = ^{vif.bank_we, vif.bank_din, vif.cfg_bank, r_bank_sel};
  assign vif.bank_ab   = '0;
`endif

endmodule

// File: tb/tb_bus_window_decoder.sv
// tb/tb_bus_window_decoder.sv - self-checking bench for bus_window_decoder
module tb_bus_window_decoder;

  localparam int AW     = 16;
  localparam int NREG   = 8;
  localparam int WS_W   = 3;
  localparam int BANK_W = 3;
`ifdef BUS_WINDOW_BANK_EN
  localparam bit BANK_EN = 1'b1;
`else
  localparam bit BANK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_window_decoder_if #(.AW(AW), .NREG(NREG), .WS_W(WS_W), .BANK_W(BANK_W)) bif();

  bus_window_decoder #(.AW(AW), .NREG(NREG), .WS_W(WS_W), .BANK_W(BANK_W)) dut (
    .clk_sys(clk),
    .reset_n(rst_n),
    .vif    (bif)
  );

  typedef struct {
    bit        valid;
    bit [15:0] base;
    bit [15:0] mask;
    int        ws;
    bit        bank;
  } mwin_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  sel;
    bit          miss;
    int          ws;
  } vec_t;

  mwin_t model [NREG];
  int    model_bank;
  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int winner(input logic [15:0] a);
    for (int i = 0; i < NREG; i++)
      if (model[i].valid && (((a ^ model[i].base) & model[i].mask) == 16'h0)) return i;
    return -1;
  endfunction

  function automatic int exp_bank(input int w);
    if (BANK_EN && w >= 0 && model[w].bank) return model_bank;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model[i] = '{1'b0, 16'h0, 16'h0, 0, 1'b0};
    model_bank = 0;
  endtask

  task automatic cfg_drive(input int idx, input logic [15:0] base, input logic [15:0] mask,
                           input int ws, input bit bank);
    bif.cfg_we   = 1'b1;
    bif.cfg_idx  = 3'(idx);
    bif.cfg_base = base;
    bif.cfg_mask = mask;
    bif.cfg_ws   = 3'(ws);
    bif.cfg_bank = bank;
    model[idx]   = '{1'b1, base, mask, ws, bank};
  endtask

  task automatic cfg_write(input int idx, input logic [15:0] base, input logic [15:0] mask,
                           input int ws, input bit bank);
    cfg_drive(idx, base, mask, ws, bank);
    step();
    bif.cfg_we = 1'b0;
  endtask

  task automatic bank_write(input int v);
    bif.bank_we  = 1'b1;
    bif.bank_din = 3'(v);
    step();
    bif.bank_we  = 1'b0;
    model_bank   = v;
  endtask

  task automatic access_exp(input logic [15:0] addr, input logic [7:0] e_sel, input bit e_miss,
                            input int e_ws, input int e_bank, input int hold, input string tag);
    bif.cpu_ab   = addr;
    bif.cpu_mreq = 1'b1;
    step();
    check({tag, ".sel"}, 32'(bif.sel), 32'(e_sel));
    check({tag, ".miss"}, 32'(bif.miss), 32'(e_miss));
    check({tag, ".bank_ab"}, 32'(bif.bank_ab), 32'(e_bank));
    for (int c = 0; c < e_ws; c++) begin
      check({tag, ".wait_lo"}, 32'(bif.wait_n), 32'd0);
      bif.cpu_ab = 16'($urandom);
      step();
    end
    check({tag, ".wait_hi"}, 32'(bif.wait_n), 32'd1);
    for (int h = 0; h < hold; h++) begin
      bif.cpu_ab = 16'($urandom);
      step();
      check({tag, ".sel_hold"}, 32'(bif.sel), 32'(e_sel));
      check({tag, ".wait_hold"}, 32'(bif.wait_n), 32'd1);
    end
    bif.cpu_mreq = 1'b0;
    step();
    check({tag, ".end_sel"}, 32'(bif.sel), 32'd0);
    check({tag, ".end_miss"}, 32'(bif.miss), 32'd0);
    check({tag, ".end_wait"}, 32'(bif.wait_n), 32'd1);
    check({tag, ".end_bank"}, 32'(bif.bank_ab), 32'd0);
  endtask

  task automatic access_model(input logic [15:0] addr, input int hold, input string tag);
    int w;
    w = winner(addr);
    access_exp(addr, (w < 0) ? 8'h0 : 8'(1 << w), (w < 0), (w < 0) ? 0 : model[w].ws,
               exp_bank(w), hold, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bif.cfg_we = 0; bif.cfg_idx = 0; bif.cfg_base = 0; bif.cfg_mask = 0;
    bif.cfg_ws = 0; bif.cfg_bank = 0; bif.cpu_ab = 0; bif.cpu_mreq = 1'b1;
    bif.bank_we = 0; bif.bank_din = 0;
    model_reset();

    step();
    step();
    check("rst.sel", 32'(bif.sel), 32'd0);
    check("rst.miss", 32'(bif.miss), 32'd0);
    check("rst.wait_n", 32'(bif.wait_n), 32'd1);
    check("rst.bank_ab", 32'(bif.bank_ab), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("rel.no_decode_miss", 32'(bif.miss), 32'd0);
    check("rel.no_decode_sel", 32'(bif.sel), 32'd0);
    check("rel.wait_n", 32'(bif.wait_n), 32'd1);
    bif.cpu_mreq = 1'b0;
    step();

    cfg_write(0, 16'h0000, 16'h8000, 0, 1'b0);
    cfg_write(1, 16'hC000, 16'hC000, 2, 1'b0);
    vecs[0] = '{16'h0123, 8'b0000_0001, 1'b0, 0};
    vecs[1] = '{16'hC123, 8'b0000_0010, 1'b0, 2};
    vecs[2] = '{16'h9000, 8'b0000_0000, 1'b1, 0};
    vecs[3] = '{16'h7FFF, 8'b0000_0001, 1'b0, 0};
    vecs[4] = '{16'hFFFF, 8'b0000_0010, 1'b0, 2};
    vecs[5] = '{16'hBFFF, 8'b0000_0000, 1'b1, 0};
    for (int v = 0; v < 6; v++)
      access_exp(vecs[v].addr, vecs[v].sel, vecs[v].miss, vecs[v].ws, 0, v % 3, $sformatf("vec%0d", v));

    cfg_write(3, 16'h1000, 16'hF000, 1, 1'b0);
    access_exp(16'h1000, 8'b0000_0001, 1'b0, 0, 0, 0, "ovl_w0");
    cfg_write(0, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    access_exp(16'h1000, 8'b0000_1000, 1'b0, 1, 0, 1, "ovl_w3");

    cfg_write(2, 16'hA000, 16'hF000, 5, 1'b0);
    bif.cpu_ab = 16'hA000;
    bif.cpu_mreq = 1'b1;
    step();
    check("abort.sel", 32'(bif.sel), 32'b0100);
    check("abort.w1", 32'(bif.wait_n), 32'd0);
    step();
    check("abort.w2", 32'(bif.wait_n), 32'd0);
    bif.cpu_mreq = 1'b0;
    step();
    check("abort.wait_n", 32'(bif.wait_n), 32'd1);
    check("abort.sel_clr", 32'(bif.sel), 32'd0);
    check("abort.miss", 32'(bif.miss), 32'd0);
    access_exp(16'hA123, 8'b0000_0100, 1'b0, 5, 0, 0, "abort_retry");

    bif.cpu_ab = 16'hC123;
    bif.cpu_mreq = 1'b1;
    cfg_drive(1, 16'h4000, 16'hC000, 0, 1'b0);
    step();
    bif.cfg_we = 1'b0;
    check("same_cyc.sel", 32'(bif.sel), 32'b0010);
    check("same_cyc.w1", 32'(bif.wait_n), 32'd0);
    cfg_drive(1, 16'h4000, 16'hC000, 3, 1'b0);
    step();
    bif.cfg_we = 1'b0;
    check("mid_cfg.w2", 32'(bif.wait_n), 32'd0);
    check("mid_cfg.sel", 32'(bif.sel), 32'b0010);
    step();
    check("mid_cfg.hold", 32'(bif.wait_n), 32'd1);
    bif.cpu_mreq = 1'b0;
    step();
    access_model(16'hC123, 0, "new_cfg_miss");
    access_model(16'h4567, 1, "new_cfg_hit");

    cfg_write(1, 16'h4000, 16'hC000, 1, 1'b1);
    bank_write(5);
    access_exp(16'h4001, 8'b0000_0010, 1'b0, 1, BANK_EN ? 5 : 0, 0, "bank_on");
    access_exp(16'hA000, 8'b0000_0100, 1'b0, 5, 0, 0, "bank_off");
    bif.cpu_ab = 16'h4001;
    bif.cpu_mreq = 1'b1;
    step();
    check("bank_mid.before", 32'(bif.bank_ab), BANK_EN ? 32'd5 : 32'd0);
    bif.bank_we = 1'b1;
    bif.bank_din = 3'd3;
    step();
    bif.bank_we = 1'b0;
    model_bank = 3;
    check("bank_mid.after", 32'(bif.bank_ab), BANK_EN ? 32'd3 : 32'd0);
    check("bank_mid.hold", 32'(bif.wait_n), 32'd1);
    bif.cpu_mreq = 1'b0;
    step();
    check("bank_mid.end", 32'(bif.bank_ab), 32'd0);

    bif.cpu_ab = 16'hA000;
    bif.cpu_mreq = 1'b1;
    step();
    check("rst_mid.wait_lo", 32'(bif.wait_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.sel", 32'(bif.sel), 32'd0);
    check("rst_mid.wait_n", 32'(bif.wait_n), 32'd1);
    check("rst_mid.miss", 32'(bif.miss), 32'd0);
    check("rst_mid.bank_ab", 32'(bif.bank_ab), 32'd0);
    bif.cpu_mreq = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    access_model(16'h1000, 0, "post_reset");

    for (int i = 0; i < NREG; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        logic [15:0] m;
        case ($urandom_range(0, 3))
          0:       m = 16'h0000;
          1:       m = 16'hFFFF << $urandom_range(0, 15);
          2:       m = 16'($urandom);
          default: m = 16'hFFFF;
        endcase
        cfg_write(i, 16'($urandom), m, $urandom_range(0, 7), 1'($urandom));
      end
    end
    for (int n = 0; n < 150; n++) begin
      logic [15:0] a;
      int j;
      if (n % 10 == 9)
        cfg_write($urandom_range(0, NREG - 1), 16'($urandom), 16'hFFFF << $urandom_range(0, 15),
                  $urandom_range(0, 7), 1'($urandom));
      if (n % 25 == 24) bank_write($urandom_range(0, 7));
      j = $urandom_range(0, NREG - 1);
      if ($urandom_range(0, 1) == 1)
        a = (model[j].base & model[j].mask) | (16'($urandom) & ~model[j].mask);
      else
        a = 16'($urandom);
      access_model(a, $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
